// File: rtl/imem_loader_pkg.sv
// Shared definitions for the program-memory loader: FSM encoding and
// memory-port constants that the RAM side also relies on.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam int   WORD_BYTES = 4;
  localparam logic MEM_WRITE  = 1'b1;
  localparam logic SIZE_WORD  = 1'b1;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and ram256x8-style write port of the loader.
// Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready
// never depends on in_valid, and the source holds in_byte stable while in_valid is high.
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_E;
  logic              mem_RW;
  logic              mem_Size;
  logic [ADDR_W-1:0] mem_A;
  logic [31:0]       mem_DI;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_E, mem_RW, mem_Size, mem_A, mem_DI
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_E, mem_RW, mem_Size, mem_A, mem_DI
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Collects bytes into a big-endian 32-bit word (first byte lands in bits[31:24]).
// word_full flags that the next shift completes a word; word_next previews it.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  assign word_next = {word_q[23:0], byte_in};
  assign word_full = (cnt_q == 2'(WORD_BYTES - 1));

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift) begin
      word_d = word_next;
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program-memory writer: receives length, big-endian words and an XOR checksum,
// writes each word to memory and keeps the CPU in reset until the image checks out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          R,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output state_t        dbg_state
);

  state_t            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        word_idx_q, word_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic              mem_e_q, mem_e_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [31:0]       mem_di_q, mem_di_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic              rx_ready;
  logic              accept;
  logic              pk_clear;
  logic              pk_shift;
  logic              pk_full;
  logic [31:0]       pk_word_next;

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (R),
    .clear     (pk_clear),
    .shift     (pk_shift),
    .byte_in   (bus.in_byte),
    .word_next (pk_word_next),
    .word_full (pk_full)
  );

  assign rx_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign accept   = bus.in_valid && rx_ready;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    mem_e_d    = 1'b0;
    mem_a_d    = mem_a_q;
    mem_di_d   = mem_di_q;
    done_d     = done_q;
    err_d      = err_q;
    cpu_hold_d = cpu_hold_q;
    pk_clear   = 1'b0;
    pk_shift   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN;
          csum_d     = '0;
          word_idx_d = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
          pk_clear   = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept) begin
          n_d = bus.in_byte;
          if (int'(bus.in_byte) > MAX_WORDS) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (bus.in_byte == 8'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          pk_shift = 1'b1;
          csum_d   = csum_q ^ bus.in_byte;
          // Register the write port on the completing byte so mem_E is high exactly in WRITE.
          if (pk_full) begin
            state_d  = ST_WRITE;
            mem_e_d  = MEM_WRITE;
            mem_a_d  = ADDR_W'(BASE_ADDR) + ADDR_W'({word_idx_q, 2'b00});
            mem_di_d = pk_word_next;
          end
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + 8'd1;
        state_d    = (word_idx_q + 8'd1 == n_q) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (accept) begin
          if (bus.in_byte == csum_q) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      word_idx_q <= '0;
      csum_q     <= '0;
      mem_e_q    <= 1'b0;
      mem_a_q    <= '0;
      mem_di_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      csum_q     <= csum_d;
      mem_e_q    <= mem_e_d;
      mem_a_q    <= mem_a_d;
      mem_di_q   <= mem_di_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign bus.in_ready = rx_ready;
  assign bus.mem_E    = mem_e_q;
  assign bus.mem_RW   = mem_e_q;
  assign bus.mem_Size = SIZE_WORD;
  assign bus.mem_A    = mem_a_q;
  assign bus.mem_DI   = mem_di_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads against a queue-based model of the image format:
// expected writes are derived from the word list, the checksum from its bytes.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 64;
  localparam int BASE_ADDR = 0;

  // clock / reset
  logic clk;
  logic rst_n;
  logic start;
  logic cpu_hold, done, err;
  state_t dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk       (clk),
    .R         (rst_n),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] exp_a_q[$];
  logic [31:0]       exp_q[$];
  logic [31:0]       img_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: every write pulse must match the next expected address/data
  always @(negedge clk) begin
    if (rst_n && bus.mem_E === 1'b1) begin
      chk("write_in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("write_rw", 32'(bus.mem_RW), 32'd1);
      chk("write_size", 32'(bus.mem_Size), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(bus.mem_A), 32'hFFFF_FFFF);
      end else begin
        chk("write_addr", 32'(bus.mem_A), 32'(exp_a_q.pop_front()));
        chk("write_data", bus.mem_DI, exp_q.pop_front());
      end
    end
  end

  // driver tasks: all called and returning at a negedge
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, input bit stray);
    int gap;
    bit taken;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      start = stray && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      start = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    taken = 1'b0;
    for (int i = 0; i < 50 && !taken; i++) begin
      if (bus.in_ready === 1'b1) begin
        taken = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    if (!taken) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbytes, input int gap_max, input bit stray);
    for (int b = 3; b > 3 - nbytes; b--) send_byte(w[8*b +: 8], gap_max, stray);
  endtask

  function automatic logic [7:0] image_csum();
    logic [7:0] c = 8'h00;
    logic [31:0] w;
    for (int k = 0; k < img_q.size(); k++) begin
      w = img_q[k];
      c = c ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    return c;
  endfunction

  task automatic expect_write(input int k, input logic [31:0] w);
    exp_a_q.push_back(ADDR_W'(BASE_ADDR + 4 * k));
    exp_q.push_back(w);
  endtask

  task automatic run_load(input string tag, input int gap_max, input bit stray, input bit bad_csum);
    int n;
    logic [7:0] c;
    n = img_q.size();
    for (int k = 0; k < n; k++) expect_write(k, img_q[k]);
    c = image_csum() ^ (bad_csum ? 8'h01 : 8'h00);
    pulse_start();
    chk({tag, "_hold_after_start"}, 32'(cpu_hold), 32'd1);
    send_byte(8'(n), gap_max, 1'b0);
    for (int k = 0; k < n; k++) send_word(img_q[k], 4, gap_max, stray);
    send_byte(c, gap_max, 1'b0);
    bus.in_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), bad_csum ? 32'd0 : 32'd1);
    chk({tag, "_err"}, 32'(err), bad_csum ? 32'd1 : 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), bad_csum ? 32'd1 : 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_mem_E"}, 32'(bus.mem_E), 32'd0);
    chk({tag, "_mem_RW"}, 32'(bus.mem_RW), 32'd0);
    chk({tag, "_mem_A"}, 32'(bus.mem_A), 32'd0);
    chk({tag, "_mem_DI"}, bus.mem_DI, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // T1: two-word image, back-to-back bytes
    img_q = '{32'hE3A01005, 32'hE2811003};
    run_load("t1", 0, 1'b0, 1'b0);

    // T2: empty image
    img_q = {};
    run_load("t2", 0, 1'b0, 1'b0);

    // T3: length one past the limit, then a clean restart
    pulse_start();
    send_byte(8'(MAX_WORDS + 1), 0, 1'b0);
    bus.in_valid = 1'b0;
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("t3_no_writes", 32'(exp_q.size()), 32'd0);
    img_q = '{32'hE3A01005, 32'hE2811003};
    run_load("t3_restart", 0, 1'b0, 1'b0);

    // T4: one random word with a corrupted checksum
    img_q = '{$urandom()};
    run_load("t4", 0, 1'b0, 1'b1);

    // T5: asynchronous reset two bytes into word 2 of a 3-word load
    img_q = '{$urandom(), $urandom(), $urandom()};
    expect_write(0, img_q[0]);
    expect_write(1, img_q[1]);
    pulse_start();
    send_byte(8'd3, 0, 1'b0);
    send_word(img_q[0], 4, 0, 1'b0);
    send_word(img_q[1], 4, 0, 1'b0);
    send_word(img_q[2], 2, 0, 1'b0);
    bus.in_valid = 1'b0;
    chk("t5_partial_writes", 32'(exp_q.size()), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_load("t5_reload", 0, 1'b0, 1'b0);

    // T6: random gaps and stray start pulses on the T1 image
    for (int r = 0; r < 3; r++) begin
      img_q = '{32'hE3A01005, 32'hE2811003};
      run_load("t6", 3, 1'b1, 1'b0);
    end

    // random images, including the largest accepted length
    for (int r = 0; r < 4; r++) begin
      img_q = {};
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) img_q.push_back($urandom());
      run_load("rand", 2, 1'b1, ($urandom_range(0, 3) == 0));
    end
    img_q = {};
    for (int k = 0; k < MAX_WORDS; k++) img_q.push_back($urandom());
    run_load("max_len", 1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
